muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit with HI/LO registers for the MIPS pipeline, sitting beside the EX-stage ALU. It decodes the R-type mult/div/move funct codes that the combinational ALU decode leaves unhandled. It runs multi-cycle shift-add multiply and restoring divide, and issues stall/done handshakes to the pipeline. Width is generic and supports signed and unsigned operands.

---
 rtl/muldiv_if.sv | 20 ++
 rtl/muldiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// EX-stage request/response bundle for the HI/LO multiply/divide unit.
interface muldiv_if #(parameter int DATA_W = 32);
    logic              op_valid_i;
    logic [5:0]        funct_i;
    logic [DATA_W-1:0] rs_i;
    logic [DATA_W-1:0] rt_i;
    logic              flush_i;
    logic              busy_o;
    logic              stall_o;
    logic              done_o;
    logic              dz_o;
    logic [DATA_W-1:0] rd_data_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    modport master (output op_valid_i, funct_i, rs_i, rt_i, flush_i,
                    input  busy_o, stall_o, done_o, dz_o, rd_data_o, hi_o, lo_o);
    modport slave  (input  op_valid_i, funct_i, rs_i, rt_i, flush_i,
                    output busy_o, stall_o, done_o, dz_o, rd_data_o, hi_o, lo_o);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiply / restoring divide with HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier (divide stays iterative).
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d;
    logic busy_q, busy_d, done_q, done_d, dz_q, dz_d;

    logic                is_md, is_known, signed_op, a_neg, b_neg;
    logic [DATA_W-1:0]   a_abs, b_abs, q_fix, r_fix;
    logic [DATA_W:0]     mul_sum, div_diff;
    logic [2*DATA_W-1:0] mul_step, div_step, prod_fix;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*DATA_W-1:0] fa, fb, fast_prod;
`endif

    // funct bit0 set means the unsigned variant, bit1 set means divide
    always_comb begin
        is_md     = (bus.funct_i >= F_MULT) && (bus.funct_i <= F_DIVU);
        is_known  = is_md || ((bus.funct_i >= F_MFHI) && (bus.funct_i <= F_MTLO));
        signed_op = ~bus.funct_i[0];
        a_neg     = signed_op & bus.rs_i[DATA_W-1];
        b_neg     = signed_op & bus.rt_i[DATA_W-1];
        a_abs     = a_neg ? -bus.rs_i : bus.rs_i;
        b_abs     = b_neg ? -bus.rt_i : bus.rt_i;
    end

    // Multiply shifts the accumulator right, adding B into the upper half when the
    // low bit is set. Divide shifts left and keeps the subtraction only if it did not borrow.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_step = {mul_sum, acc_q[DATA_W-1:1]};
        div_diff = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]} - {1'b0, b_q};
        div_step = div_diff[DATA_W] ? {acc_q[2*DATA_W-2:0], 1'b0}
                                    : {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        prod_fix = neg_q  ? -acc_q : acc_q;
        q_fix    = neg_q  ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
        r_fix    = rneg_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
    end

`ifdef MULDIV_FAST_MUL_EN
    // Operands extended to full product width so the truncated product is exact
    always_comb begin
        fa        = signed_op ? {{DATA_W{bus.rs_i[DATA_W-1]}}, bus.rs_i} : {{DATA_W{1'b0}}, bus.rs_i};
        fb        = signed_op ? {{DATA_W{bus.rt_i[DATA_W-1]}}, bus.rt_i} : {{DATA_W{1'b0}}, bus.rt_i};
        fast_prod = fa * fb;
    end
`endif

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        busy_d   = busy_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        if (bus.flush_i) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.op_valid_i) begin
                    if (is_md) begin
                        dz_d     = 1'b0;
                        is_div_d = bus.funct_i[1];
                        b_d      = b_abs;
                        cnt_d    = CNT_W'(DATA_W);
                        busy_d   = 1'b1;
                        state_d  = CALC;
                        neg_d    = a_neg ^ b_neg;
                        rneg_d   = bus.funct_i[1] & a_neg;
                        acc_d    = {{DATA_W{1'b0}}, a_abs};
                        if (bus.funct_i[1] && bus.rt_i == '0) begin
                            // Result preloaded unsigned; SIGN just writes it out
                            dz_d    = 1'b1;
                            neg_d   = 1'b0;
                            rneg_d  = 1'b0;
                            acc_d   = {bus.rs_i, {DATA_W{1'b1}}};
                            state_d = SIGN;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        if (!bus.funct_i[1]) begin
                            neg_d   = 1'b0;
                            acc_d   = fast_prod;
                            state_d = SIGN;
                        end
`endif
                    end else if (bus.funct_i == F_MTHI) begin
                        hi_d = bus.rs_i;
                    end else if (bus.funct_i == F_MTLO) begin
                        lo_d = bus.rs_i;
                    end
                end
                CALC: begin
                    acc_d = is_div_q ? div_step : mul_step;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = SIGN;
                end
                SIGN: begin
                    if (is_div_q) begin
                        hi_d = r_fix;
                        lo_d = q_fix;
                    end else begin
                        hi_d = prod_fix[2*DATA_W-1:DATA_W];
                        lo_d = prod_fix[DATA_W-1:0];
                    end
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.stall_o   = bus.op_valid_i & is_known & (busy_q | (state_q != IDLE));
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.dz_o      = dz_q;
    assign bus.hi_o      = hi_q;
    assign bus.lo_o      = lo_q;
    assign bus.rd_data_o = (bus.funct_i == F_MFHI) ? hi_q : lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized ops
// against a 64-bit arithmetic model, and hand sequences for stall/flush/reset.
module tb_muldiv_unit;
    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MFLO_GAP = 0;
`else
    localparam int MUL_LAT  = W + 1;
    localparam int MFLO_GAP = 4;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    muldiv_if #(.DATA_W(W)) bif ();
    muldiv_unit #(.DATA_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a, b, hi, lo;
        logic        dz;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, SV division truncates toward zero
    task automatic model(input logic [5:0] f, input logic [31:0] a, b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint sa, sb;
        logic [63:0] p, q, r;
        dz = 1'b0;
        if (f[0]) begin sa = {32'b0, a}; sb = {32'b0, b}; end
        else begin sa = $signed(a); sb = $signed(b); end
        if (!f[1]) begin
            p = sa * sb;
            hi = p[63:32]; lo = p[31:0];
        end else if (b == 0) begin
            hi = a; lo = '1; dz = 1'b1;
        end else begin
            q = sa / sb; r = sa % sb;
            hi = r[31:0]; lo = q[31:0];
        end
    endtask

    function automatic int exp_lat(input logic [5:0] f, input logic [31:0] b);
        if (!f[1]) return MUL_LAT;
        return (b == 0) ? 1 : W + 1;
    endfunction

    // Issue at e0, then count edges until done_o is seen
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, b, output int lat);
        bif.funct_i = f; bif.rs_i = a; bif.rt_i = b; bif.op_valid_i = 1'b1;
        @(posedge clk); #1;
        bif.op_valid_i = 1'b0;
        chk("busy_after_e0", bif.busy_o, 1);
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (bif.done_o) begin lat = n; break; end
        end
    endtask

    task automatic op_check(input string tag, input logic [5:0] f, input logic [31:0] a, b);
        logic [31:0] eh, el;
        logic ed;
        int lat;
        model(f, a, b, eh, el, ed);
        run_op(f, a, b, lat);
        chk({tag, "_lat"}, lat, exp_lat(f, b));
        chk({tag, "_hi"}, bif.hi_o, eh);
        chk({tag, "_lo"}, bif.lo_o, el);
        chk({tag, "_dz"}, bif.dz_o, ed);
        @(posedge clk); #1;
        chk({tag, "_done_1cyc"}, bif.done_o, 0);
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        bif.op_valid_i = 1'b1; bif.funct_i = 6'h11; bif.rs_i = h;
        @(posedge clk); #1;
        bif.funct_i = 6'h13; bif.rs_i = l;
        @(posedge clk); #1;
        bif.op_valid_i = 1'b0;
    endtask

    initial begin
        vec_t vt [10];
        logic [31:0] eh, el;
        logic ed;
        int n;
        bit seen;

        vt[0] = '{6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vt[1] = '{6'h18, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vt[2] = '{6'h1A, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vt[3] = '{6'h1B, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vt[4] = '{6'h1B, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 1'b1};
        vt[5] = '{6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        vt[6] = '{6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        1'b0};
        vt[7] = '{6'h1A, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vt[8] = '{6'h1A, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
        vt[9] = '{6'h19, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0};

        bif.op_valid_i = 1'b0; bif.funct_i = '0; bif.rs_i = '0; bif.rt_i = '0; bif.flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_hi", bif.hi_o, 0);
        chk("rst_lo", bif.lo_o, 0);
        chk("rst_busy", bif.busy_o, 0);
        chk("rst_done", bif.done_o, 0);
        chk("rst_dz", bif.dz_o, 0);
        @(posedge clk); #1;

        // Directed vectors with mfhi/mflo readback
        for (int i = 0; i < 10; i++) begin
            int lat;
            run_op(vt[i].f, vt[i].a, vt[i].b, lat);
            chk($sformatf("vec%0d_lat", i), lat, exp_lat(vt[i].f, vt[i].b));
            chk($sformatf("vec%0d_hi", i), bif.hi_o, vt[i].hi);
            chk($sformatf("vec%0d_lo", i), bif.lo_o, vt[i].lo);
            chk($sformatf("vec%0d_dz", i), bif.dz_o, vt[i].dz);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_1cyc", i), bif.done_o, 0);
            bif.op_valid_i = 1'b1; bif.funct_i = 6'h10; #1;
            chk($sformatf("vec%0d_mfhi", i), bif.rd_data_o, vt[i].hi);
            chk($sformatf("vec%0d_mfhi_nostall", i), bif.stall_o, 0);
            bif.funct_i = 6'h12; #1;
            chk($sformatf("vec%0d_mflo", i), bif.rd_data_o, vt[i].lo);
            bif.op_valid_i = 1'b0;
            @(posedge clk); #1;
        end

        // Randomized ops against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [5:0]  f;
            logic [31:0] a, b;
            f = 6'h18 + 6'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 7) == 0) b = 0;
            else if ($urandom_range(0, 1) == 1) b = $urandom;
            else b = $urandom_range(1, 20);
            op_check($sformatf("rnd%0d", i), f, a, b);
        end

        // mflo issued while a mult is in flight is held until busy drops
        model(6'h18, 32'd5, 32'hFFFFFFF7, eh, el, ed);
        bif.funct_i = 6'h18; bif.rs_i = 32'd5; bif.rt_i = 32'hFFFFFFF7; bif.op_valid_i = 1'b1;
        @(posedge clk); #1;
        bif.op_valid_i = 1'b0;
        repeat (MFLO_GAP) @(posedge clk);
        #1 bif.op_valid_i = 1'b1; bif.funct_i = 6'h12; #1;
        chk("mflo_stall", bif.stall_o, 1);
        n = 0;
        while (bif.stall_o && n < 100) begin @(posedge clk); #1; n++; end
        chk("mflo_stall_timeout", n < 100, 1);
        chk("mflo_busy_low", bif.busy_o, 0);
        chk("mflo_data", bif.rd_data_o, el);
        bif.op_valid_i = 1'b0;
        @(posedge clk); #1;

        // mthi while a div is busy stalls, then lands after the div result
        bif.funct_i = 6'h1B; bif.rs_i = 32'd100; bif.rt_i = 32'd7; bif.op_valid_i = 1'b1;
        @(posedge clk); #1;
        bif.op_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 bif.op_valid_i = 1'b1; bif.funct_i = 6'h11; bif.rs_i = 32'h1234;
        #1 chk("mthi_stall", bif.stall_o, 1);
        n = 0;
        while (bif.stall_o && n < 100) begin @(posedge clk); #1; n++; end
        chk("mthi_stall_timeout", n < 100, 1);
        chk("mthi_div_hi", bif.hi_o, 2);
        @(posedge clk); #1;
        bif.op_valid_i = 1'b0;
        chk("mthi_written", bif.hi_o, 32'h1234);

        // Flush at cycle 10 of a div
        write_hilo(32'hAAAA5555, 32'h12345678);
        bif.funct_i = 6'h1B; bif.rs_i = 32'd1000; bif.rt_i = 32'd3; bif.op_valid_i = 1'b1;
        @(posedge clk); #1;
        bif.op_valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 bif.flush_i = 1'b1;
        @(posedge clk); #1;
        bif.flush_i = 1'b0;
        chk("flush_busy", bif.busy_o, 0);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (bif.done_o) seen = 1'b1; end
        chk("flush_no_done", seen, 0);
        chk("flush_hi_kept", bif.hi_o, 32'hAAAA5555);
        chk("flush_lo_kept", bif.lo_o, 32'h12345678);

        // Flush landing on the SIGN edge suppresses the write
        bif.funct_i = 6'h19; bif.rs_i = 32'd3; bif.rt_i = 32'd3; bif.op_valid_i = 1'b1;
        @(posedge clk); #1;
        bif.op_valid_i = 1'b0;
        repeat (MUL_LAT - 1) @(posedge clk);
        #1 bif.flush_i = 1'b1;
        @(posedge clk); #1;
        bif.flush_i = 1'b0;
        chk("sflush_done", bif.done_o, 0);
        chk("sflush_busy", bif.busy_o, 0);
        chk("sflush_lo_kept", bif.lo_o, 32'h12345678);
        @(posedge clk); #1;
        chk("sflush_done_later", bif.done_o, 0);

        // Unknown funct: no stall, no state change
        bif.op_valid_i = 1'b1; bif.funct_i = 6'h20; bif.rs_i = 32'hDEAD; #1;
        chk("add_nostall", bif.stall_o, 0);
        @(posedge clk); #1;
        bif.op_valid_i = 1'b0;
        chk("add_busy", bif.busy_o, 0);
        chk("add_hi_kept", bif.hi_o, 32'hAAAA5555);

        // Flush beats a simultaneous mult in IDLE
        bif.op_valid_i = 1'b1; bif.funct_i = 6'h18; bif.rs_i = 32'd9; bif.rt_i = 32'd9; bif.flush_i = 1'b1;
        @(posedge clk); #1;
        bif.op_valid_i = 1'b0; bif.flush_i = 1'b0;
        chk("fidle_busy", bif.busy_o, 0);
        @(posedge clk); #1;
        chk("fidle_done", bif.done_o, 0);
        chk("fidle_lo_kept", bif.lo_o, 32'h12345678);

        // Async reset at cycle 20 of a mult clears HI/LO immediately
        bif.funct_i = 6'h18; bif.rs_i = 32'd77; bif.rt_i = 32'd55; bif.op_valid_i = 1'b1;
        @(posedge clk); #1;
        bif.op_valid_i = 1'b0;
        repeat (19) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_hi", bif.hi_o, 0);
        chk("mrst_lo", bif.lo_o, 0);
        chk("mrst_busy", bif.busy_o, 0);
        chk("mrst_done", bif.done_o, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        op_check("post_rst", 6'h1B, 32'd100, 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
